uart_rx_ctrl_p: RTL and testbench
=================================

Name: uart_rx_ctrl_p

Overview:
- Parametrised, self-contained UART receive controller for the UART_RX path: frame FSM, edge/bit counters, 3-sample majority voter and deserializer in one block.
- Generalises the fixed 8-bit receive FSM with:
  - configurable data width;
  - runtime oversampling, parity type and 1/2 stop bits;
  - start-glitch rejection;
  - mid-stop-bit frame completion, so back-to-back frames are received with no idle gap.
- Feeds P_DATA/data_valid to the downstream data synchroniser.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9), LSB first.
- PRESC_W, 6, width of Prescale input / edge counter.

Ports:
- clk_RX  input  1  oversampling clock.
- rst  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line, already synchronous to clk_RX; idle high.
- Prescale  input  PRESC_W  oversampling ratio; legal even values 8..32.
- PAR_EN  input  1  1 = parity bit present.
- PAR_TYP  input  1  0 = even, 1 = odd.
- STOP2  input  1  1 = two stop bits.
- P_DATA  output  DATA_WIDTH  last good frame data.
- data_valid  output  1  one-cycle pulse, P_DATA updated.
- parity_error  output  1  one-cycle pulse at frame end.
- stop_error  output  1  one-cycle pulse at frame end.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: async, active-low, forces state IDLE and clears every register.
  - Outputs at reset: P_DATA=0, data_valid=0, parity_error=0, stop_error=0, busy=0.
  - Reset mid-frame discards the partial frame; no pulse is generated.
- Configuration latch: Prescale, PAR_EN, PAR_TYP and STOP2 are latched on the IDLE->START transition. Changes mid-frame are ignored until the next frame.
  - Prescale<8 is latched as 8. Odd values use half = Prescale>>1.
- Counters:
  - edge_cnt runs 0..Prescale-1 and wraps at each bit boundary.
  - bit_cnt counts bits within the frame.
  - Both are cleared on entry to START.
- Sampling: RX_IN is captured at edge_cnt = half-1, half and half+1. The majority of the three is the bit value, used on the clock edge where edge_cnt = half+1.
- FSM:
  - IDLE: when RX_IN==0, go to START on the next edge (edge_cnt=0).
  - START: at edge_cnt = half+1, majority==1 is a glitch. Return to IDLE with no pulses.
    - Otherwise stay in START until edge_cnt = Prescale-1, then go to DATA.
  - DATA: shift the majority bit into the shift register (LSB first) at each sample point.
    - After DATA_WIDTH bits, at edge_cnt = Prescale-1, go to PARITY if PAR_EN=1, else STOP.
  - PARITY: at the sample point compute perr = (majority != expected).
    - expected = ^data for even, ~^data for odd.
    - Go to STOP at edge_cnt = Prescale-1. The frame is never aborted on a parity error.
  - STOP: sample each stop bit; serr is set if any stop sample is 0.
    - With STOP2=1 the first stop bit runs its full length and the second is sampled.
    - The frame completes at the sample point (edge_cnt = half+1) of the final stop bit.
- Frame completion: on the cycle after the completion edge, FSM is in IDLE and exactly one of these holds:
  - no error: data_valid=1 for 1 cycle and P_DATA = shift register;
  - errors: parity_error and/or stop_error pulse for 1 cycle (both may pulse together), data_valid=0 and P_DATA holds its old value.
  - busy drops in that same cycle.
- Back-to-back frames: IDLE is reached half a bit early, so a start bit immediately following the stop bit is detected. A new START may begin in the cycle right after a pulse.
- Line held low after a stop error (break): restarts START each frame. A low line that persists produces repeated stop_error pulses and never a data_valid.
- Outputs are registered; no combinational path from RX_IN to any output.

Test Plan:
- Single frame: Prescale=8, PAR_EN=1, PAR_TYP=0, STOP2=0, frame 0xA5 with parity 0 -> one data_valid pulse, P_DATA=0xA5, no error pulses; busy high for exactly 10.5 bit times (84±1 clocks).
- Parity error: same setup with parity bit 1 -> parity_error pulses once, data_valid stays 0, P_DATA keeps 0xA5.
- Odd parity, two stop bits: Prescale=16, PAR_TYP=1, STOP2=1, 0x3C with parity 1 -> data_valid once; a stop_error pulse occurs if the second stop bit is driven 0.
- Glitch rejection: RX_IN low for 3 clocks at Prescale=16 -> FSM returns to IDLE, no pulses.
  - A single-clock low spike in a mid-bit sample window is outvoted; data unchanged.
- Back-to-back: 4 frames 0x00, 0xFF, 0x55, 0x81 with no gap at Prescale=32, PAR_EN=0 -> 4 data_valid pulses with correct data in order.
- Reset and reconfiguration: rst asserted in the middle of the DATA state -> all outputs 0 immediately and no pulse. A Prescale change mid-frame does not affect the current frame.

Source files
------------

// File: rtl/uart_rx_ctrl_p_if.sv
// Receive-path bundle between the serial line/config source and the UART RX controller.
// master: drives RX_IN and the frame config (Prescale, PAR_EN, PAR_TYP, STOP2), observes results.
// slave : the controller; drives P_DATA, data_valid, parity_error, stop_error, busy.
interface uart_rx_ctrl_p_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
);
    logic                  RX_IN;
    logic [PRESC_W-1:0]    Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  parity_error;
    logic                  stop_error;
    logic                  busy;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP, STOP2,
        input  P_DATA, data_valid, parity_error, stop_error, busy
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP, STOP2,
        output P_DATA, data_valid, parity_error, stop_error, busy
    );
endinterface

// File: rtl/uart_rx_ctrl_p.sv
// UART receive controller: frame FSM, edge/bit counters, 3-sample majority voter, deserializer.
// Ports: clk_RX/rst (async active-low) plain; serial line, config and results via uart_rx_ctrl_p_if.slave.
// Result pulses appear the cycle after the final stop-bit sample point; no backpressure (pulse interface).
module uart_rx_ctrl_p #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic               clk_RX,
    input  logic               rst,
    uart_rx_ctrl_p_if.slave    bus
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [PRESC_W-1:0]    edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [PRESC_W-1:0]    presc_q;
    logic [PRESC_W-1:0]    half_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  stop2_q;
    logic                  smp0;
    logic                  smp1;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  perr_q;
    logic                  serr_q;

    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_valid_q;
    logic                  parity_error_q;
    logic                  stop_error_q;

    logic [PRESC_W-1:0]    presc_eff;
    logic                  at_s0;
    logic                  at_s1;
    logic                  at_smp;
    logic                  at_end;
    logic                  maj;
    logic                  last_data;
    logic                  last_stop;

    logic                  frame_good;
    logic                  frame_perr;
    logic                  frame_serr;

    // Ratios below 8 leave too few clocks for a centred 3-sample window.
    assign presc_eff = (bus.Prescale < PRESC_W'(8)) ? PRESC_W'(8) : bus.Prescale;

    assign at_s0     = (edge_cnt == half_q - PRESC_W'(1));
    assign at_s1     = (edge_cnt == half_q);
    assign at_smp    = (edge_cnt == half_q + PRESC_W'(1));
    assign at_end    = (edge_cnt == presc_q - PRESC_W'(1));
    // Third vote is the live line value on the sample-point edge.
    assign maj       = (smp0 & smp1) | (smp0 & bus.RX_IN) | (smp1 & bus.RX_IN);
    assign last_data = (bit_cnt == BW'(DATA_WIDTH - 1));
    assign last_stop = !stop2_q || (bit_cnt == BW'(1));

    // State register
    always_ff @(posedge clk_RX or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!bus.RX_IN) state_nxt = START;
            end
            START: begin
                if (at_smp && maj)  state_nxt = IDLE;   // start glitch
                else if (at_end)    state_nxt = DATA;
            end
            DATA: begin
                if (at_end && last_data) state_nxt = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (at_end) state_nxt = STOP;
            end
            STOP: begin
                // Completing mid-bit lets IDLE catch a start bit that follows with no gap.
                if (at_smp && last_stop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: frame verdict on the final stop sample point
    always_comb begin
        frame_good = 1'b0;
        frame_perr = 1'b0;
        frame_serr = 1'b0;
        if (state == STOP && at_smp && last_stop) begin
            frame_perr = perr_q;
            frame_serr = serr_q | ~maj;
            frame_good = !frame_perr && !frame_serr;
        end
    end

    // Counters, config latch, voter samples, deserializer, registered outputs
    always_ff @(posedge clk_RX or negedge rst) begin
        if (!rst) begin
            edge_cnt       <= '0;
            bit_cnt        <= '0;
            presc_q        <= '0;
            half_q         <= '0;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            stop2_q        <= 1'b0;
            smp0           <= 1'b0;
            smp1           <= 1'b0;
            shreg          <= '0;
            perr_q         <= 1'b0;
            serr_q         <= 1'b0;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                bit_cnt <= '0;
                if (!bus.RX_IN) begin
                    // The detecting edge is edge 0 of the start bit, so the count resumes at 1
                    // and edge_cnt stays aligned with the clocks elapsed since the falling edge.
                    edge_cnt  <= PRESC_W'(1);
                    presc_q   <= presc_eff;
                    half_q    <= presc_eff >> 1;
                    par_en_q  <= bus.PAR_EN;
                    par_typ_q <= bus.PAR_TYP;
                    stop2_q   <= bus.STOP2;
                    perr_q    <= 1'b0;
                    serr_q    <= 1'b0;
                end else begin
                    edge_cnt <= '0;
                end
            end else if (state_nxt == IDLE) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                edge_cnt <= at_end ? '0 : edge_cnt + PRESC_W'(1);
                if (at_end) begin
                    if (state == DATA)
                        bit_cnt <= last_data ? '0 : bit_cnt + BW'(1);
                    else if (state == STOP)
                        bit_cnt <= bit_cnt + BW'(1);
                end
            end

            if (at_s0) smp0 <= bus.RX_IN;
            if (at_s1) smp1 <= bus.RX_IN;

            if (state == DATA && at_smp)
                shreg <= {maj, shreg[DATA_WIDTH-1:1]};
            if (state == PARITY && at_smp)
                perr_q <= (maj != (par_typ_q ? ~^shreg : ^shreg));
            if (state == STOP && at_smp && !maj)
                serr_q <= 1'b1;

            data_valid_q   <= frame_good;
            parity_error_q <= frame_perr;
            stop_error_q   <= frame_serr;
            if (frame_good) p_data_q <= shreg;
        end
    end

    assign bus.P_DATA       = p_data_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.parity_error = parity_error_q;
    assign bus.stop_error   = stop_error_q;
    assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl_p.sv
// Self-checking bench for uart_rx_ctrl_p: directed frames plus randomized frames.
// Expected results come from a frame-level model (bits -> data/parity/stop verdict).
// Observed result pulses are queued by a monitor and compared in order per phase.
module tb_uart_rx_ctrl_p;

    localparam int DW = 8;
    localparam int PW = 6;

    logic clk_RX = 1'b0;
    logic rst    = 1'b0;

    always #5 clk_RX = ~clk_RX;

    uart_rx_ctrl_p_if #(.DATA_WIDTH(DW), .PRESC_W(PW)) bus ();

    uart_rx_ctrl_p #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
        .clk_RX (clk_RX),
        .rst    (rst),
        .bus    (bus.slave)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    int          busy_total = 0;
    logic [7:0]  last_good = 8'h00;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_ev(input logic dv, input logic pe, input logic se,
                                          input logic [7:0] d);
        return {21'd0, dv, pe, se, d};
    endfunction

    always @(negedge clk_RX) begin
        if (bus.busy) busy_total++;
        if (bus.data_valid || bus.parity_error || bus.stop_error)
            obs_q.push_back(mk_ev(bus.data_valid, bus.parity_error, bus.stop_error, bus.P_DATA));
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive(input logic v, input int n);
        bus.RX_IN = v;
        repeat (n) @(negedge clk_RX);
    endtask

    // One frame, p clocks per bit. spk >= 0 flips one clock in the middle of data bit spk.
    // bad_stop pulls the final stop bit low through its sample window only.
    task automatic send_frame(input int p, input logic pe_en, input logic pt, input logic st2,
                              input logic [7:0] d, input logic bad_par, input logic bad_stop,
                              input int spk, input logic scramble, input logic [PW-1:0] presc_drv);
        int   half;
        logic lvl;
        logic bits[$];
        half = p / 2;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe_en) bits.push_back((pt ? ~^d : ^d) ^ bad_par);
        bits.push_back(1'b1);
        if (st2) bits.push_back(1'b1);
        bus.Prescale = presc_drv;
        bus.PAR_EN   = pe_en;
        bus.PAR_TYP  = pt;
        bus.STOP2    = st2;
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < p; c++) begin
                lvl = bits[b];
                if (spk >= 0 && b == spk + 1 && c == half) lvl = ~lvl;
                if (bad_stop && b == bits.size() - 1 && c <= half + 1) lvl = 1'b0;
                bus.RX_IN = lvl;
                @(negedge clk_RX);
                if (scramble && b == 0 && c == 0) begin
                    bus.Prescale = PW'($urandom);
                    bus.PAR_EN   = 1'($urandom);
                    bus.PAR_TYP  = 1'($urandom);
                    bus.STOP2    = 1'($urandom);
                end
            end
        end
        bus.RX_IN = 1'b1;
        if (!(pe_en && bad_par) && !bad_stop) begin
            exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, d));
            last_good = d;
        end else begin
            exp_q.push_back(mk_ev(1'b0, pe_en && bad_par, bad_stop, last_good));
        end
    endtask

    task automatic phase_check(input string tag);
        int t;
        int n;
        t = 0;
        while (bus.busy && t < 5000) begin
            @(negedge clk_RX);
            t++;
        end
        chk($sformatf("%s_idle", tag), {31'd0, bus.busy}, 32'd0);
        repeat (4) @(negedge clk_RX);
        chk($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk($sformatf("%s_pdata", tag), {24'd0, bus.P_DATA}, 32'd0);
        chk($sformatf("%s_dv", tag),    {31'd0, bus.data_valid}, 32'd0);
        chk($sformatf("%s_pe", tag),    {31'd0, bus.parity_error}, 32'd0);
        chk($sformatf("%s_se", tag),    {31'd0, bus.stop_error}, 32'd0);
        chk($sformatf("%s_busy", tag),  {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int b0;
        int bl;
        int dvc;
        int sec;
        int p;
        logic [PW-1:0] pd;
        logic pe_en, pt, st2, bpar, bstop, scr;
        int spk;

        bus.RX_IN    = 1'b1;
        bus.Prescale = PW'(8);
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        bus.STOP2    = 1'b0;
        repeat (3) @(negedge clk_RX);
        check_outputs_zero("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk_RX);

        // Single good frame with even parity; busy spans 10.5 bit times
        b0 = busy_total;
        send_frame(8, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, -1, 1'b0, PW'(8));
        phase_check("a5");
        bl = busy_total - b0;
        chk($sformatf("busy_len_84pm1_was_%0d", bl), {31'd0, (bl >= 83 && bl <= 85)}, 32'd1);

        // Parity error keeps the previous data
        send_frame(8, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, -1, 1'b0, PW'(8));
        phase_check("par_err");
        chk("par_err_hold", {24'd0, bus.P_DATA}, 32'h0000_00A5);

        // Odd parity, two stop bits; then the second stop bit pulled low
        send_frame(16, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, -1, 1'b0, PW'(16));
        send_frame(16, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, -1, 1'b0, PW'(16));
        phase_check("odd_stop2");

        // Start glitch: 3 low clocks at Prescale=16
        bus.Prescale = PW'(16);
        bus.PAR_EN   = 1'b0;
        drive(1'b0, 3);
        drive(1'b1, 40);
        phase_check("glitch");

        // Single-clock spike in a sample window, config scrambled mid-frame, Prescale<8 clamps to 8
        send_frame(16, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 3, 1'b1, PW'(16));
        send_frame(8, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 6, 1'b0, PW'(5));
        phase_check("spike_clamp");

        // Back-to-back, no idle gap
        send_frame(32, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, -1, 1'b0, PW'(32));
        send_frame(32, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, -1, 1'b0, PW'(32));
        send_frame(32, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, -1, 1'b0, PW'(32));
        send_frame(32, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, -1, 1'b0, PW'(32));
        phase_check("b2b");

        // Break: line held low yields repeated stop errors and never data_valid
        bus.Prescale = PW'(8);
        bus.PAR_EN   = 1'b0;
        bus.STOP2    = 1'b0;
        drive(1'b0, 300);
        dvc = 0;
        sec = 0;
        foreach (obs_q[i]) begin
            dvc += int'(obs_q[i][10]);
            sec += int'(obs_q[i][8]);
        end
        chk("break_dv", dvc, 0);
        chk($sformatf("break_se_ge3_was_%0d", sec), {31'd0, (sec >= 3)}, 32'd1);
        rst = 1'b0;
        #1;
        check_outputs_zero("break_rst");
        @(negedge clk_RX);
        bus.RX_IN = 1'b1;
        rst = 1'b1;
        obs_q.delete();
        exp_q.delete();
        last_good = 8'h00;
        repeat (4) @(negedge clk_RX);

        // Reset in the middle of DATA discards the frame
        send_frame(8, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, -1, 1'b0, PW'(8));
        phase_check("pre_rst");
        bus.Prescale = PW'(8);
        drive(1'b0, 8);
        drive(1'b1, 8);
        drive(1'b0, 12);
        chk("mid_busy_before_rst", {31'd0, bus.busy}, 32'd1);
        rst = 1'b0;
        #1;
        check_outputs_zero("mid_rst");
        @(negedge clk_RX);
        rst = 1'b1;
        last_good = 8'h00;
        drive(1'b1, 200);
        phase_check("post_rst");

        // Randomized frames with random config, gaps, errors, spikes and mid-frame config noise
        for (int f = 0; f < 40; f++) begin
            p     = 2 * $urandom_range(4, 16);
            pd    = PW'(p);
            if (p == 8 && $urandom_range(0, 1) == 1) pd = PW'($urandom_range(0, 7));
            pe_en = 1'($urandom);
            pt    = 1'($urandom);
            st2   = 1'($urandom);
            bpar  = pe_en && ($urandom_range(0, 4) == 0);
            bstop = ($urandom_range(0, 5) == 0);
            spk   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
            scr   = 1'($urandom);
            send_frame(p, pe_en, pt, st2, 8'($urandom), bpar, bstop, spk, scr, pd);
            drive(1'b1, p * int'($urandom_range(0, 1)));
        end
        phase_check("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
